// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back arbiter for the register file's single write port.
// Single-cycle (main) results win the port; MUL/DIV results wait in a small FIFO
// and drain when main is idle or when the starvation counter forces main_hold.
// A per-register scoreboard marks in-flight MUL/DIV destinations so decode can stall.
module wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            main_valid,
    input  logic [4:0]      main_rd,
    input  logic [XLEN-1:0] main_data,
    output logic            main_hold,
    input  logic            md_issue,
    input  logic [4:0]      md_issue_rd,
    input  logic            md_done_valid,
    input  logic [4:0]      md_done_rd,
    input  logic [XLEN-1:0] md_done_data,
    output logic            md_done_ready,
    input  logic [4:0]      rs1addr_rf,
    input  logic [4:0]      rs2addr_rf,
    input  logic [4:0]      dec_rd,
    output logic            stall,
    output logic            wen_rf,
    output logic [4:0]      write_addr_rf,
    output logic [XLEN-1:0] write_data_rf
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]      fifo_rd_q   [FIFO_DEPTH];
    logic [4:0]      fifo_rd_d   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [31:0]     sb_q, sb_d;

    logic fifo_empty;
    logic fifo_full;
    logic main_wr;
    logic pop;
    logic push;

    // Same-cycle arbitration: any main_valid owns the slot (even rd=0), else the FIFO head drains
    always_comb begin
        fifo_empty    = (count_q == '0);
        fifo_full     = (count_q == CW'(FIFO_DEPTH));
        main_wr       = main_valid && (main_rd != 5'd0);
        pop           = !main_valid && !fifo_empty;
        push          = md_done_valid && !fifo_full;
        wen_rf        = main_wr || pop;
        write_addr_rf = '0;
        write_data_rf = '0;
        if (main_wr) begin
            write_addr_rf = main_rd;
            write_data_rf = main_data;
        end else if (pop) begin
            write_addr_rf = fifo_rd_q[rd_ptr_q];
            write_data_rf = fifo_data_q[rd_ptr_q];
        end
    end

    // Status outputs derived from registered state only (main_hold is therefore registered)
    always_comb begin
        md_done_ready = !fifo_full;
        main_hold     = (starve_q == SW'(STARVE_LIMIT));
        stall         = sb_q[rs1addr_rf] | sb_q[rs2addr_rf] | sb_q[dec_rd];
    end

    // FIFO next state: push/pop may coincide, pointers wrap naturally (power-of-2 depth)
    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_rd_d[wr_ptr_q]   = md_done_rd;
            fifo_data_d[wr_ptr_q] = md_done_data;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Starvation counter and scoreboard next state; a same-cycle set beats the clear
    always_comb begin
        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (main_valid && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end
        sb_d = sb_q;
        if (pop) begin
            sb_d[fifo_rd_q[rd_ptr_q]] = 1'b0;
        end
        if (md_issue && (md_issue_rd != 5'd0)) begin
            sb_d[md_issue_rd] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    // Control state; reset drops queued results and pending bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            sb_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            sb_q     <= sb_d;
        end
    end

    // FIFO storage is qualified by count, so it needs no reset
    always_ff @(posedge clk) begin
        fifo_rd_q   <= fifo_rd_d;
        fifo_data_q <= fifo_data_d;
    end

    // Upstream must honour main_hold; a main result arriving anyway is a protocol error
    assert property (@(posedge clk) disable iff (rst) !(main_hold && main_valid));

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus random traffic against a
// queue-based reference model of the write-back rules.
module tb_wb_arbiter;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            main_valid;
    logic [4:0]      main_rd;
    logic [XLEN-1:0] main_data;
    logic            main_hold;
    logic            md_issue;
    logic [4:0]      md_issue_rd;
    logic            md_done_valid;
    logic [4:0]      md_done_rd;
    logic [XLEN-1:0] md_done_data;
    logic            md_done_ready;
    logic [4:0]      rs1addr_rf;
    logic [4:0]      rs2addr_rf;
    logic [4:0]      dec_rd;
    logic            stall;
    logic            wen_rf;
    logic [4:0]      write_addr_rf;
    logic [XLEN-1:0] write_data_rf;

    always #5 clk = ~clk;

    wb_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .main_valid(main_valid), .main_rd(main_rd), .main_data(main_data), .main_hold(main_hold),
        .md_issue(md_issue), .md_issue_rd(md_issue_rd),
        .md_done_valid(md_done_valid), .md_done_rd(md_done_rd), .md_done_data(md_done_data),
        .md_done_ready(md_done_ready),
        .rs1addr_rf(rs1addr_rf), .rs2addr_rf(rs2addr_rf), .dec_rd(dec_rd), .stall(stall),
        .wen_rf(wen_rf), .write_addr_rf(write_addr_rf), .write_data_rf(write_data_rf)
    );

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    // Reference model state: queued MD results, pending registers, consecutive losses
    ent_t       mq[$];
    bit         sb[32];
    int         starve;
    logic [4:0] outq[$];

    int n_chk = 0;
    int n_err = 0;

    // Values observed in the most recent step
    logic            o_wen;
    logic [4:0]      o_addr;
    logic [XLEN-1:0] o_data;
    logic            o_hold, o_ready, o_stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        main_valid    = 1'b0; main_rd = '0; main_data = '0;
        md_issue      = 1'b0; md_issue_rd = '0;
        md_done_valid = 1'b0; md_done_rd = '0; md_done_data = '0;
        rs1addr_rf    = '0; rs2addr_rf = '0; dec_rd = '0;
    endtask

    function automatic bit model_stall(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        return sb[a] | sb[b] | sb[c];
    endfunction

    // One clock: compare outputs against the model mid-cycle, then advance the model at the edge
    task automatic step();
        bit              exp_wen, exp_ready, popped;
        logic [4:0]      exp_addr;
        logic [XLEN-1:0] exp_data;
        @(negedge clk);
        o_wen = wen_rf; o_addr = write_addr_rf; o_data = write_data_rf;
        o_hold = main_hold; o_ready = md_done_ready; o_stall = stall;
        exp_ready = (mq.size() < DEPTH);
        popped    = !main_valid && (mq.size() > 0);
        if (main_valid && main_rd != 5'd0) begin
            exp_wen = 1'b1; exp_addr = main_rd; exp_data = main_data;
        end else if (popped) begin
            exp_wen = 1'b1; exp_addr = mq[0].rd; exp_data = mq[0].data;
        end else begin
            exp_wen = 1'b0; exp_addr = '0; exp_data = '0;
        end
        chk("wen_rf", 32'(o_wen), 32'(exp_wen));
        chk("write_addr", 32'(o_addr), 32'(exp_addr));
        chk("write_data", o_data, exp_data);
        chk("md_done_ready", 32'(o_ready), 32'(exp_ready));
        chk("main_hold", 32'(o_hold), 32'(starve == LIMIT));
        chk("stall", 32'(o_stall), 32'(model_stall(rs1addr_rf, rs2addr_rf, dec_rd)));
        @(posedge clk);
        if (popped || mq.size() == 0) starve = 0;
        else if (starve < LIMIT) starve++;
        if (popped) begin
            sb[mq[0].rd] = 1'b0;
            void'(mq.pop_front());
        end
        if (md_issue && md_issue_rd != 5'd0) sb[md_issue_rd] = 1'b1;
        if (md_done_valid && exp_ready) mq.push_back('{md_done_rd, md_done_data});
        #1;
    endtask

    // Reset asserted asynchronously mid-cycle; outputs checked while it is held
    task automatic do_reset(input logic [4:0] probe_rd);
        rst = 1'b1;
        idle();
        rs1addr_rf = probe_rd;
        mq.delete(); outq.delete();
        foreach (sb[i]) sb[i] = 1'b0;
        starve = 0;
        @(negedge clk);
        chk("rst_wen", 32'(wen_rf), 32'd0);
        chk("rst_ready", 32'(md_done_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_hold", 32'(main_hold), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
    endtask

    initial begin
        int hold_at;
        int n_md;
        logic [4:0] md_seen[$];
        bit offered;
        idle();
        rst = 1'b0;
        #2;
        do_reset(5'd0);

        // Main only: same-cycle write, rd=0 writes nothing
        idle(); main_valid = 1'b1; main_rd = 5'd3; main_data = 32'hDEADBEEF;
        step();
        chk("t2_wen", 32'(o_wen), 32'd1);
        chk("t2_addr", 32'(o_addr), 32'd3);
        chk("t2_data", o_data, 32'hDEADBEEF);
        main_rd = 5'd0;
        step();
        chk("t2_rd0_wen", 32'(o_wen), 32'd0);

        // MD path: issue, stall, accept at T, write at T+1, stall clear at T+2
        idle(); md_issue = 1'b1; md_issue_rd = 5'd7; dec_rd = 5'd7;
        step();
        idle(); rs1addr_rf = 5'd7;
        step();
        chk("t3_stall_pending", 32'(o_stall), 32'd1);
        md_done_valid = 1'b1; md_done_rd = 5'd7; md_done_data = 32'h12345678;
        step();
        chk("t3_accept", 32'(o_ready), 32'd1);
        idle(); rs1addr_rf = 5'd7;
        step();
        chk("t3_wb_wen", 32'(o_wen), 32'd1);
        chk("t3_wb_addr", 32'(o_addr), 32'd7);
        chk("t3_wb_data", o_data, 32'h12345678);
        step();
        chk("t3_stall_clear", 32'(o_stall), 32'd0);

        // Collision: one queued entry starved by main until main_hold
        idle(); main_valid = 1'b1; main_rd = 5'd4; main_data = 32'h44;
        md_done_valid = 1'b1; md_done_rd = 5'd12; md_done_data = 32'hAAAA5555;
        step();
        md_done_valid = 1'b0;
        hold_at = -1;
        for (int i = 0; i < 10; i++) begin
            main_valid = (starve != LIMIT);
            step();
            if (o_hold && hold_at < 0) begin
                hold_at = i;
                chk("t4_hold_wen", 32'(o_wen), 32'd1);
                chk("t4_hold_addr", 32'(o_addr), 32'd12);
                chk("t4_hold_data", o_data, 32'hAAAA5555);
            end else if (hold_at >= 0 && i == hold_at + 1) begin
                chk("t4_hold_release", 32'(o_hold), 32'd0);
            end
        end
        chk("t4_hold_cycle", 32'(hold_at), 32'd4);

        // Full FIFO under continuous main traffic; entries drain in order
        idle(); main_rd = 5'd2; main_data = 32'h22;
        n_md = 0; md_seen.delete();
        for (int i = 0; i < 40; i++) begin
            main_valid = (starve != LIMIT);
            offered = (n_md < 3);
            md_done_valid = offered;
            md_done_rd = 5'(20 + n_md);
            md_done_data = 32'(n_md + 1);
            if (offered && mq.size() < DEPTH) n_md++;
            step();
            if (i == 2) chk("t5_full_ready", 32'(o_ready), 32'd0);
            if (o_wen && o_addr >= 5'd20) md_seen.push_back(o_addr);
        end
        chk("t5_drained", 32'(md_seen.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < md_seen.size()) chk("t5_order", 32'(md_seen[k]), 32'(20 + k));
            else chk("t5_order_missing", 32'd0, 32'(20 + k));
        end

        // Same-cycle scoreboard set and clear on rd=9
        idle(); md_issue = 1'b1; md_issue_rd = 5'd9;
        step();
        idle(); md_done_valid = 1'b1; md_done_rd = 5'd9; md_done_data = 32'h99;
        step();
        idle(); md_issue = 1'b1; md_issue_rd = 5'd9;
        step();
        chk("t6_wb_addr", 32'(o_addr), 32'd9);
        idle(); rs1addr_rf = 5'd9;
        step();
        chk("t6_sb9_set", 32'(o_stall), 32'd1);
        step();
        chk("t6_sb9_kept", 32'(o_stall), 32'd1);

        // Reset mid-run with two queued entries and rd 5 pending
        do_reset(5'd0);
        idle(); md_issue = 1'b1; md_issue_rd = 5'd5; dec_rd = 5'd5;
        step();
        idle(); main_valid = 1'b1; main_rd = 5'd1;
        md_done_valid = 1'b1; md_done_rd = 5'd5; md_done_data = 32'h55;
        step();
        md_done_rd = 5'd6; md_done_data = 32'h66;
        step();
        do_reset(5'd5);
        for (int i = 0; i < 4; i++) begin
            idle(); rs1addr_rf = 5'd5;
            step();
            chk("t1_no_write", 32'(o_wen), 32'd0);
            chk("t1_stall", 32'(o_stall), 32'd0);
        end

        // Random traffic obeying the decode and hold protocol
        for (int i = 0; i < 500; i++) begin
            logic [4:0] r;
            idle();
            rs1addr_rf = 5'($urandom_range(0, 31));
            rs2addr_rf = 5'($urandom_range(0, 31));
            if (outq.size() > 0 && $urandom_range(0, 1) == 1) begin
                md_done_valid = 1'b1;
                md_done_rd    = outq[0];
                md_done_data  = $urandom;
            end
            if (starve != LIMIT && $urandom_range(0, 1) == 1) begin
                main_valid = 1'b1;
                main_rd    = 5'($urandom_range(0, 31));
                main_data  = $urandom;
            end
            r = 5'($urandom_range(1, 31));
            dec_rd = r;
            if ($urandom_range(0, 2) == 0 && !model_stall(rs1addr_rf, rs2addr_rf, r)) begin
                md_issue = 1'b1; md_issue_rd = r;
            end
            if (md_done_valid && mq.size() < DEPTH) void'(outq.pop_front());
            if (md_issue) outq.push_back(r);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
